// File: rtl/ll_sc_monitor.sv
// ll_sc_monitor: memory-side LL/SC reservation keeper and fixed-latency RAM access sequencer
module ll_sc_monitor #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic              cpu_ll_i,
  input  logic              cpu_sc_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_data_i,
  output logic              cpu_ack_o,
  output logic [31:0]       cpu_data_o,
  input  logic              snoop_we_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  input  logic              flush_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i,
  output logic              llbit_o,
  output logic [ADDR_W-1:0] lladdr_o
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d, ll_q, ll_d, sc_q, sc_d, llbit_q, llbit_d;
  logic [ADDR_W-1:0] addr_q, addr_d, lladdr_q, lladdr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d, res_q, res_d;
  logic              accept, last, cpu_hit, snoop_t0, sc_ok;
  always_comb begin
    accept    = state_q == IDLE && cpu_req_i;
    last      = state_q == ACCESS && cnt_q == CW'(MEM_LAT - 1);
    cpu_hit   = llbit_q && (cpu_addr_i >> 2) == (lladdr_q >> 2);
    snoop_t0  = snoop_we_i && (snoop_addr_i >> 2) == (lladdr_q >> 2);
    sc_ok     = cpu_hit && !snoop_t0 && !flush_i;
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    ll_d      = ll_q;
    sc_d      = sc_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    res_d     = res_q;
    llbit_d   = llbit_q;
    lladdr_d  = lladdr_q;
    if (accept) begin
      addr_d  = cpu_addr_i;
      sel_d   = cpu_sel_i;
      wdata_d = cpu_data_i;
      sc_d    = cpu_sc_i;
      ll_d    = cpu_ll_i && !cpu_sc_i;
      we_d    = cpu_sc_i || (!cpu_ll_i && cpu_we_i);
      cnt_d   = '0;
      res_d   = {31'b0, cpu_sc_i && sc_ok};
      state_d = (cpu_sc_i && !sc_ok) ? DONE : ACCESS;
      if (!cpu_sc_i && !cpu_ll_i && cpu_we_i && cpu_hit) llbit_d = 1'b0;
    end
    if (state_q == ACCESS) begin
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? DONE : ACCESS;
      res_d   = (last && !we_q) ? mem_data_i : res_q;
    end
    if (state_q == DONE) begin
      state_d = IDLE;
      if (ll_q) begin
        llbit_d  = 1'b1;
        lladdr_d = {addr_q[ADDR_W-1:2], 2'b00};
      end
      if (sc_q && res_q[0]) llbit_d = 1'b0;
    end
    // clearing events are checked against the reservation as it will stand after this edge
    if (snoop_we_i && (snoop_addr_i >> 2) == (lladdr_d >> 2)) llbit_d = 1'b0;
    if (flush_i) llbit_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      ll_q     <= 1'b0;
      sc_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      res_q    <= '0;
      llbit_q  <= 1'b0;
      lladdr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      ll_q     <= ll_d;
      sc_q     <= sc_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      res_q    <= res_d;
      llbit_q  <= llbit_d;
      lladdr_q <= lladdr_d;
    end
  end
  assign cpu_ack_o  = state_q == DONE;
  assign cpu_data_o = cpu_ack_o ? res_q : 32'b0;
  assign mem_ce_o   = state_q == ACCESS;
  assign mem_we_o   = mem_ce_o && we_q;
  assign mem_addr_o = addr_q;
  assign mem_sel_o  = sel_q;
  assign mem_data_o = wdata_q;
  assign llbit_o    = llbit_q;
  assign lladdr_o   = lladdr_q;
endmodule

// File: tb/tb_ll_sc_monitor.sv
// tb_ll_sc_monitor: randomized LL/SC traffic against a reservation/RAM reference model with a
// scoreboard queue drained by an independent ack monitor.
module tb_ll_sc_monitor;
  localparam int LAT = 3;
  logic        clk = 0, rst = 0;
  logic        cpu_req_i = 0, cpu_we_i = 0, cpu_ll_i = 0, cpu_sc_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, snoop_addr_i = 0;
  logic [3:0]  cpu_sel_i = 0;
  logic        snoop_we_i = 0, flush_i = 0;
  logic        cpu_ack_o, mem_ce_o, mem_we_o, llbit_o;
  logic [31:0] cpu_data_o, mem_addr_o, mem_data_o, mem_data_i, lladdr_o;
  logic [3:0]  mem_sel_o;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram[8], init_v[8], model[8];
  bit          ram_load = 1;
  int          ce_run = 0;
  bit          rs_v = 0;
  logic [31:0] rs_addr = 0;

  ll_sc_monitor #(.MEM_LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_ll_i(cpu_ll_i),
    .cpu_sc_i(cpu_sc_i), .cpu_addr_i(cpu_addr_i), .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i),
    .cpu_ack_o(cpu_ack_o), .cpu_data_o(cpu_data_o), .snoop_we_i(snoop_we_i),
    .snoop_addr_i(snoop_addr_i), .flush_i(flush_i), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .llbit_o(llbit_o), .lladdr_o(lladdr_o));

  always #5 clk = ~clk;

  // RAM with fixed latency: read data only in the last enabled cycle, writes commit there too
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8; i++) ram[i] <= init_v[i];
      ce_run <= 0;
    end else if (mem_ce_o) begin
      ce_run <= ce_run + 1;
      if (mem_we_o && ce_run == LAT - 1)
        for (int b = 0; b < 4; b++)
          if (mem_sel_o[b]) ram[mem_addr_o[4:2]][8*b+:8] <= mem_data_o[8*b+:8];
    end else ce_run <= 0;
  end
  assign mem_data_i = (mem_ce_o && ce_run == LAT - 1) ? ram[mem_addr_o[4:2]] : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (cpu_ack_o) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else chk("ack_data", cpu_data_o, exp_q.pop_front());
      end else chk("idle_data_zero", cpu_data_o, 32'd0);
    end
  end

  // kind: 0 load, 1 store, 2 LL, 3 SC; event et (1 flush, 2 snoop to ea) driven in cycle ek of the op
  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int ek, input int et, input logic [31:0] ea);
    bit ok, hit, stable;
    int dd, lim, ack_n, ces;
    logic [31:0] exp;
    hit = et == 1 || (et == 2 && ea[31:2] == rs_addr[31:2]);
    ok  = kind == 3 && rs_v && a[31:2] == rs_addr[31:2] && !(ek == 0 && hit);
    if (kind == 1 && rs_v && a[31:2] == rs_addr[31:2]) rs_v = 0;
    if (ek == 0 && hit) rs_v = 0;
    dd  = (kind == 3 && !ok) ? 1 : LAT + 1;
    exp = (kind == 0 || kind == 2) ? model[a[4:2]] : {31'b0, ok};
    if (kind == 1 || ok)
      for (int b = 0; b < 4; b++) if (s[b]) model[a[4:2]][8*b+:8] = d[8*b+:8];
    exp_q.push_back(exp);
    lim = ek > dd ? ek : dd;
    ack_n = -1; ces = 0; stable = 1;
    for (int n = 0; n <= lim; n++) begin
      @(negedge clk);
      if (cpu_ack_o && ack_n < 0) ack_n = n;
      if (n == 0) begin
        cpu_we_i = kind == 1 || (kind >= 2 && $urandom_range(0, 1) == 1);
        cpu_ll_i = kind == 2; cpu_sc_i = kind == 3;
        cpu_addr_i = a; cpu_data_i = d; cpu_sel_i = s;
      end
      cpu_req_i = ack_n < 0;
      snoop_we_i = n == ek && et == 2; flush_i = n == ek && et == 1; snoop_addr_i = ea;
      if (mem_ce_o) begin
        ces++;
        if (mem_addr_o !== a || mem_sel_o !== s || mem_we_o !== (kind == 1 || kind == 3) ||
            (mem_we_o && mem_data_o !== d)) stable = 0;
      end
      if (n == dd) begin
        if (kind == 2) begin rs_v = 1; rs_addr = {a[31:2], 2'b00}; end
        if (ok) rs_v = 0;
      end
      if (n > 0 && n == ek && (et == 1 || (et == 2 && ea[31:2] == rs_addr[31:2]))) rs_v = 0;
    end
    @(negedge clk);
    cpu_req_i = 0; snoop_we_i = 0; flush_i = 0;
    chk("ack_cycle", ack_n, dd);
    chk("ce_cycles", ces, (kind == 3 && !ok) ? 0 : LAT);
    chk("mem_stable", {31'b0, stable}, 32'd1);
    chk("llbit", {31'b0, llbit_o}, {31'b0, rs_v});
    if (rs_v) chk("lladdr", lladdr_o, rs_addr);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin init_v[i] = $urandom; model[i] = init_v[i]; end
    init_v[0] = 32'h1234; model[0] = 32'h1234;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cpu_ack_o, cpu_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o,
        mem_data_o, llbit_o, lladdr_o} == '0 ? 32'd0 : 32'd1, 32'd0);
    rst = 1; ram_load = 0;
    @(negedge clk);
    do_op(2, 32'h0, 0, 4'hF, -1, 0, 0);
    do_op(3, 32'h0, 32'h5678, 4'hF, -1, 0, 0);
    do_op(0, 32'h0, 0, 4'hF, -1, 0, 0);
    do_op(3, 32'h0, 32'hAAAA, 4'hF, -1, 0, 0);
    do_op(2, 32'h0, 0, 4'hF, LAT + 2, 2, 32'h2);
    do_op(3, 32'h0, 32'h1111, 4'hF, -1, 0, 0);
    do_op(2, 32'h0, 0, 4'hF, LAT + 2, 2, 32'h8);
    do_op(3, 32'h0, 32'h2222, 4'hF, -1, 0, 0);
    do_op(2, 32'h4, 0, 4'hF, LAT + 2, 1, 0);
    do_op(3, 32'h4, 32'h3333, 4'hF, -1, 0, 0);
    do_op(2, 32'h4, 0, 4'hF, LAT + 1, 1, 0);
    do_op(2, 32'h4, 0, 4'hF, -1, 0, 0);
    do_op(3, 32'h5, 32'h4444, 4'hF, 0, 2, 32'h6);
    do_op(2, 32'h4, 0, 4'hF, -1, 0, 0);
    do_op(3, 32'h4, 32'h5555, 4'h3, 1, 2, 32'h4);
    do_op(2, 32'hC, 0, 4'hF, -1, 0, 0);
    do_op(1, 32'h8, 32'h6666, 4'hF, -1, 0, 0);
    do_op(1, 32'hD, 32'h7777, 4'h2, -1, 0, 0);
    do_op(3, 32'hC, 32'h8888, 4'hF, -1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      int ek, et;
      ek = $urandom_range(0, 2) == 0 ? $urandom_range(0, LAT + 2) : -1;
      et = ek < 0 ? 0 : $urandom_range(1, 3) == 1 ? 1 : 2;
      do_op($urandom_range(0, 3), $urandom_range(0, 15), $urandom, 4'($urandom_range(1, 15)),
            ek, et, $urandom_range(0, 15));
    end
    do_op(2, 32'h10, 0, 4'hF, -1, 0, 0);
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 0; cpu_ll_i = 0; cpu_sc_i = 0; cpu_addr_i = 32'h8; cpu_sel_i = 4'hF;
    @(negedge clk);
    cpu_req_i = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("midreset_outputs", {cpu_ack_o, cpu_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o,
        mem_data_o, llbit_o, lladdr_o} == '0 ? 32'd0 : 32'd1, 32'd0);
    rs_v = 0; rs_addr = 0;
    @(negedge clk);
    rst = 1;
    repeat (6) @(negedge clk);
    chk("midreset_llbit", {31'b0, llbit_o}, 32'd0);
    do_op(0, 32'h8, 0, 4'hF, -1, 0, 0);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ll_sc_monitor.md
Name: ll_sc_monitor

Overview:
- Memory-side responder for the CPU's LL/SC atomic pair. It sits between the core's data-memory port and the data RAM.
- Holds the link reservation (LLbit plus word address) on the memory side and arbitrates each SC as success or failure.
- Clears the reservation on conflicting writes from the core or a second bus master (snoop), and on exception flush.
- Sequences every access to a RAM with fixed read latency through a request/ack handshake.

Parameters:
- MEM_LAT, 1, RAM access latency in cycles (>=1); read data valid on mem_data_i in the last cycle of mem_ce_o.
- ADDR_W, 32, address width; the reservation compares bits [ADDR_W-1:2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- cpu_req_i  in  1  access request; held until cpu_ack_o.
- cpu_we_i  in  1  store (ignored when cpu_ll_i or cpu_sc_i is set).
- cpu_ll_i  in  1  request is LL (load + set reservation).
- cpu_sc_i  in  1  request is SC (conditional store).
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_sel_i  in  4  byte enables.
- cpu_data_i  in  32  store data.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_data_o  out  32  load data; for SC, 1 = success, 0 = failure.
- snoop_we_i  in  1  other-master write strobe.
- snoop_addr_i  in  ADDR_W  other-master write address.
- flush_i  in  1  exception/ERET flush; clears the reservation.
- mem_ce_o  out  1  RAM chip enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_sel_o  out  4  RAM byte enables.
- mem_data_o  out  32  RAM write data.
- mem_data_i  in  32  RAM read data.
- llbit_o  out  1  reservation valid (debug/visibility).
- lladdr_o  out  ADDR_W  reserved word address, low 2 bits zero.

Behaviour:
- Reset (rst=0, any time, including mid-access):
  - state goes to IDLE;
  - all outputs become 0, including llbit_o and lladdr_o;
  - no ack is issued for the aborted access.
- States: IDLE, ACCESS, DONE. Counter cnt is sized to hold MEM_LAT.
- IDLE with cpu_req_i=1 (acceptance cycle, T0):
  - LL or plain load/store: latch address, sel, data, and kind; go to ACCESS with cnt=0.
  - SC: the success condition is evaluated in T0 as llbit=1 AND addr[ADDR_W-1:2]==lladdr[ADDR_W-1:2] AND no clearing event in T0.
  - SC success: go to ACCESS as a write.
  - SC failure: go directly to DONE with result 0; there is no RAM access.
- ACCESS:
  - mem_ce_o=1 for exactly MEM_LAT cycles (T1..T_MEM_LAT); mem_we_o, mem_addr_o, mem_sel_o, and mem_data_o are held stable throughout.
  - In the last cycle, capture mem_data_i (reads), then go to DONE.
- DONE:
  - cpu_ack_o=1 for one cycle; cpu_data_o is valid in that cycle only and is 0 otherwise.
  - Next state is IDLE; a new request can be accepted in the following cycle.
- Latency:
  - load/store/LL/successful SC: ack in cycle T(MEM_LAT+1);
  - failed SC: ack in T1.
- cpu_data_o per access kind:
  - loads and LL return the read word;
  - stores return 0;
  - SC returns 32'h1 on success, 32'h0 on failure.
- Reservation update (clock edge; lower entries in this list take priority):
  - LL completing (DONE): llbit=1, lladdr=word address.
  - Successful SC reaching DONE: llbit=0.
  - Core store (cpu_we_i, non-SC) accepted to the reserved word: llbit=0.
  - snoop_we_i=1 with snoop word == lladdr word, any state: llbit=0.
  - flush_i=1, any state: llbit=0.
- Priority consequences:
  - A flush or snoop hit in the same cycle an LL completes leaves llbit=0.
  - A snoop hit or flush in the SC acceptance cycle makes that SC fail.
  - Once an SC is committed to ACCESS, later snoops or flushes cannot abort the write; they still clear llbit.
- Address rules:
  - Only the word address is compared; a byte-offset difference still matches.
  - A store to a different word leaves the reservation intact.
- A second LL replaces the reservation address.
- cpu_req_i deasserted while not in IDLE is ignored; the access completes.

Test Plan:
- MEM_LAT=1, RAM[0x0]=0x00001234. LL 0x0 -> ack in T2 with data 0x00001234, llbit_o=1, lladdr_o=0x0. SC 0x0 with data 0x00005678 -> ack in T2 with data 1, RAM[0x0]=0x00005678, llbit_o=0.
- SC 0x0 with no reservation -> ack in T1 with data 0, mem_ce_o never asserted, RAM unchanged.
- LL 0x0, then snoop_we_i to 0x2, then SC 0x0 -> SC returns 0 and RAM keeps its value. Repeat with the snoop to 0x8 -> SC returns 1.
- LL 0x4, then flush_i pulse, then SC 0x4 -> returns 0. LL 0x4 with flush_i asserted in its DONE cycle -> llbit_o=0.
- MEM_LAT=3: load 0x8 -> mem_ce_o high for exactly 3 cycles, ack in T4, address and data held stable. Assert rst=0 during the 2nd ACCESS cycle -> all outputs 0 immediately and no ack afterwards.
- SC acceptance cycle coinciding with a snoop hit -> result 0. Snoop hit one cycle after the SC is accepted -> result 1, write performed, llbit_o=0.
